e_muldiv: RTL and testbench
===========================

// Module: e_muldiv
// PURPOSE
//  Multi-cycle multiply/divide unit in the E stage, alongside the ALU, fed by the forwarded E-stage rs/rt values.
//  Owns the HI/LO registers.
//  Executes mult/multu/div/divu with fixed latency, and mthi/mtlo in one cycle.
//  Drives busy to the stall unit, which stalls D-stage md-class instructions while start||busy.
// PARAMETERS
//  MUL_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES  10  busy cycles for div/divu (>=1)
// PORTS
//  clk    in   1   clock, rising edge
//  reset  in   1   asynchronous, active-high; clears all state
//  start  in   1   one-cycle request; op/A/B valid in the same cycle
//  op     in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 nop
//  A      in   32  rs operand (already forwarded)
//  B      in   32  rt operand (already forwarded)
//  busy   out  1   operation in flight
//  HI     out  32  HI register
//  LO     out  32  LO register
// BEHAVIOUR
//  Reset (async, any time): busy=0, HI=0, LO=0, counter=0, FSM->IDLE.
//   Any in-flight operation is discarded.
//  FSM states:
//   IDLE: start=1 with op 0-3 latches A/B/op, loads counter with MUL_CYCLES or DIV_CYCLES, goes to RUN.
//    busy is 1 from the next cycle.
//   RUN: counter decrements each cycle.
//    On the edge where counter==1: HI/LO take the result, busy drops to 0, FSM returns to IDLE.
//    So busy is high for exactly N cycles, and the result is visible in the cycle busy first reads 0.
//  mthi/mtlo: with start=1 in IDLE, HI (or LO) <= A at the next edge. busy stays 0.
//  op 6/7 with start=1: no effect.
//  start while busy: ignored entirely. Operands are not re-latched and HI/LO are unchanged.
//   The stall unit guarantees this never happens in-system.
//  HI/LO hold their old values throughout RUN; results are committed only at completion.
//  Result rules:
//   mult: {HI,LO} = signed A * signed B, full 64-bit product.
//   multu: {HI,LO} = unsigned 64-bit product.
//   div: LO = quotient truncated toward zero; HI = remainder, sign follows the dividend.
//   divu: unsigned quotient in LO, unsigned remainder in HI.
//  Boundary cases:
//   B==0 for div/divu: the full latency still elapses; HI and LO are left unchanged.
//   div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
//  The arithmetic may be computed combinationally at latch time and held; only the timing contract above is visible.
//  There is no flush input: an operation issued before a branch/jump commits (no delay-slot kill in this core).
// TESTING
//  1) Reset mid-RUN: reset pulse -> busy=0, HI=LO=0 immediately (asynchronous, no clock edge needed).
//  2) mult A=0xFFFFFFFE(-2), B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//     Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
//  3) div A=0xFFFFFFF9(-7), B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     divu A=7, B=2 -> LO=3, HI=1.
//  4) Setup mthi A=0x1234, then mtlo A=0x5678. Then div by B=0 -> busy 10 cycles, HI=0x1234, LO=0x5678 unchanged.
//  5) mult 3*4 started; at busy cycle 2, pulse start with divu 100/7.
//     -> second request ignored; final HI=0, LO=12 after exactly 5 busy cycles.
//  6) Back-to-back: mult completes, start divu 9/2 in the first cycle busy==0.
//     -> accepted; LO=4, HI=1 after 10 busy cycles.

Source files
------------

// File: rtl/e_muldiv.sv
// E-stage multiply/divide unit owning HI/LO.
// Fixed-latency mult/multu/div/divu; single-cycle mthi/mtlo.
//
// Ports:
//   clk   - clock, rising edge
//   reset - async active-high, clears all state
//   start - one-cycle request, op/A/B valid with it
//   op    - 0 mult, 1 multu, 2 div, 3 divu,
//           4 mthi, 5 mtlo, 6-7 nop
//   A, B  - forwarded rs/rt operands
//   busy  - operation in flight
//   HI/LO - architectural HI/LO registers
module e_muldiv #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC =
    (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [1:0]    op_q;

  logic signed [63:0] smul;
  logic        [63:0] umul;
  logic        [31:0] dv_u;
  logic        [31:0] dv_s;
  logic               ovf;
  logic               bz;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic        [31:0] uq;
  logic        [31:0] ur;
  logic        [31:0] hi_d;
  logic        [31:0] lo_d;

  assign smul = $signed(a_q) * $signed(b_q);
  assign umul = 64'(a_q) * 64'(b_q);

  // Divisors are forced to 1 when the real one would be
  // zero (result discarded anyway) or when dividing
  // INT_MIN by -1; dividing by 1 then yields exactly the
  // required 0x80000000 quotient and zero remainder.
  assign bz   = (b_q == 32'd0);
  assign ovf  = (a_q == 32'h8000_0000) &&
                (b_q == 32'hFFFF_FFFF);
  assign dv_u = bz ? 32'd1 : b_q;
  assign dv_s = (bz || ovf) ? 32'd1 : b_q;

  assign sq = $signed(a_q) / $signed(dv_s);
  assign sr = $signed(a_q) % $signed(dv_s);
  assign uq = a_q / dv_u;
  assign ur = a_q % dv_u;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    unique case (1'b1)
      (op_q == 2'd0): begin
        hi_d = smul[63:32];
        lo_d = smul[31:0];
      end
      (op_q == 2'd1): begin
        hi_d = umul[63:32];
        lo_d = umul[31:0];
      end
      (op_q == 2'd2): begin
        if (!bz) begin
          hi_d = sr;
          lo_d = sq;
        end
      end
      default: begin
        if (!bz) begin
          hi_d = ur;
          lo_d = uq;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            unique case (1'b1)
              (op[2] == 1'b0): begin
                a_q     <= A;
                b_q     <= B;
                op_q    <= op[1:0];
                cnt_q   <= op[1] ? CW'(DIV_CYCLES)
                                 : CW'(MUL_CYCLES);
                busy_q  <= 1'b1;
                state_q <= RUN;
              end
              (op == 3'd4): hi_q <= A;
              (op == 3'd5): lo_q <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          // start is ignored here; operands stay latched
          if (cnt_q == CW'(1)) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_muldiv.sv
// Randomized self-checking bench for e_muldiv.
// Reference model uses 64-bit integer arithmetic.
module tb_e_muldiv;

  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int vecs;
  int errs;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  e_muldiv #(
    .MUL_CYCLES(MULN),
    .DIV_CYCLES(DIVN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Model: what the op does to HI/LO and its latency.
  task automatic model(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output int n);
    longint p;
    longint q;
    longint r;
    n = 0;
    case (o)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32];
        m_lo = p[31:0];
        n = MULN;
      end
      3'd1: begin
        p = longint'({32'd0, a}) * longint'({32'd0, b});
        m_hi = p[63:32];
        m_lo = p[31:0];
        n = MULN;
      end
      3'd2: begin
        if (b != 0) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          m_hi = r[31:0];
          m_lo = q[31:0];
        end
        n = DIVN;
      end
      3'd3: begin
        if (b != 0) begin
          q = longint'({32'd0, a}) / longint'({32'd0, b});
          r = longint'({32'd0, a}) % longint'({32'd0, b});
          m_hi = r[31:0];
          m_lo = q[31:0];
        end
        n = DIVN;
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op, optionally pulse a junk start at busy
  // cycle inj (1-based), then check latency and HI/LO.
  task automatic run_op(input string tag,
                        input logic [2:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int inj);
    int n;
    int en;
    logic [31:0] oh;
    logic [31:0] ol;
    oh = m_hi;
    ol = m_lo;
    @(negedge clk);
    start = 1'b1;
    op = o;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'd7;
    model(o, a, b, en);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 1) begin
        chk({tag, "_hold_hi"}, HI, oh);
        chk({tag, "_hold_lo"}, LO, ol);
      end
      if (n == inj) begin
        start = 1'b1;
        op = 3'd3;
        A = 32'd100;
        B = 32'd7;
      end else begin
        start = 1'b0;
        op = 3'd7;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'(en));
    chk({tag, "_hi"}, HI, m_hi);
    chk({tag, "_lo"}, LO, m_lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    vecs = 0;
    errs = 0;
    m_hi = '0;
    m_lo = '0;
    start = 1'b0;
    op = 3'd7;
    A = '0;
    B = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b0;

    run_op("mthi0", 3'd4, 32'hDEAD_BEEF, 32'd0, -1);
    run_op("mtlo0", 3'd5, 32'hCAFE_F00D, 32'd0, -1);
    // async reset in the middle of a mult
    @(negedge clk);
    start = 1'b1;
    op = 3'd0;
    A = 32'd9;
    B = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_hi", HI, 32'd0);
    chk("mid_rst_lo", LO, 32'd0);
    m_hi = '0;
    m_lo = '0;
    #2;
    reset = 1'b0;

    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, -1);
    run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, -1);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, -1);
    run_op("divu", 3'd3, 32'd7, 32'd2, -1);
    run_op("mthi", 3'd4, 32'h1234, 32'd0, -1);
    run_op("mtlo", 3'd5, 32'h5678, 32'd0, -1);
    run_op("div0", 3'd2, 32'd55, 32'd0, -1);
    run_op("divu0", 3'd3, 32'd55, 32'd0, -1);
    run_op("ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("nop6", 3'd6, 32'h1111, 32'h2222, -1);
    run_op("mthiz", 3'd4, 32'd0, 32'd0, -1);
    run_op("ign", 3'd0, 32'd3, 32'd4, 2);
    run_op("b2b", 3'd3, 32'd9, 32'd2, -1);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("rnd", ro, ra, rb, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1, "timeout");
  end

endmodule
